// File: rtl/test_sequencer.sv
// Runs a programmed list of memory-test descriptors back-to-back against control_block,
// with a per-test watchdog and fail aggregation. Optional macro: SEQ_STOP_ON_ERROR_EN.
module test_sequencer #(
  parameter int DESC_NUM = 4,
  parameter int TIMEOUT_W = 24,
  localparam int IDX_W = $clog2(DESC_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 desc_we_i,
  input  logic [IDX_W-1:0]     desc_idx_i,
  input  logic [2:1][31:0]     desc_data_i,
  input  logic [IDX_W:0]       seq_num_i,
  input  logic                 seq_start_i,
  output logic                 seq_busy_o,
  output logic                 seq_done_o,
  output logic [DESC_NUM-1:0]  seq_fail_mask_o,
  output logic [IDX_W-1:0]     seq_first_fail_o,
  output logic                 seq_timeout_o,
  output logic                 start_test_o,
  output logic [2:1][31:0]     test_param_o,
  input  logic                 test_finished_i,
  input  logic                 test_result_i,
  output logic [2:0]           dbg_state_o
);

  localparam logic [2:0] IDLE_S  = 3'd0;
  localparam logic [2:0] LOAD_S  = 3'd1;
  localparam logic [2:0] START_S = 3'd2;
  localparam logic [2:0] WAIT_S  = 3'd3;
  localparam logic [2:0] NEXT_S  = 3'd4;
  localparam logic [2:0] DONE_S  = 3'd5;

  localparam logic [IDX_W:0] NUM_MAX = (IDX_W + 1)'(DESC_NUM);

  logic [2:0]           state;
  logic [IDX_W-1:0]     cur_idx;
  logic [IDX_W:0]       num;
  logic [TIMEOUT_W-1:0] wd;
  logic [DESC_NUM-1:0]  fail_mask;
  logic [IDX_W-1:0]     first_fail;
  logic                 timed_out;
  logic [2:1][31:0]     param;
  logic [2:1][31:0]     slot [DESC_NUM];

  logic [IDX_W:0]       num_clamped;
  logic [TIMEOUT_W-1:0] wd_inc;
  logic                 is_last;
  logic                 no_fail_yet;

  always_comb begin
    num_clamped = (seq_num_i > NUM_MAX) ? NUM_MAX : seq_num_i;
    wd_inc      = wd + TIMEOUT_W'(1);
    is_last     = ({1'b0, cur_idx} == (num - (IDX_W + 1)'(1)));
    no_fail_yet = (fail_mask == '0);
  end

  // Handshake with control_block: start_test_o is a one-cycle pulse while test_param_o
  // is already stable; test_finished_i is a one-cycle pulse qualifying test_result_i and
  // is only honoured in WAIT_S.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE_S;
      cur_idx    <= '0;
      num        <= '0;
      wd         <= '0;
      fail_mask  <= '0;
      first_fail <= '0;
      timed_out  <= 1'b0;
      param      <= '0;
      for (int i = 0; i < DESC_NUM; i++) slot[i] <= '0;
    end else begin
      if (desc_we_i && (state == IDLE_S)) slot[desc_idx_i] <= desc_data_i;
      case (state)
        IDLE_S: begin
          if (seq_start_i) begin
            fail_mask  <= '0;
            first_fail <= '0;
            timed_out  <= 1'b0;
            num        <= num_clamped;
            cur_idx    <= '0;
            state      <= (num_clamped == '0) ? DONE_S : LOAD_S;
          end
        end
        LOAD_S: begin
          param <= slot[cur_idx];
          state <= START_S;
        end
        START_S: begin
          wd    <= '0;
          state <= WAIT_S;
        end
        WAIT_S: begin
          wd <= wd_inc;
          if (test_finished_i) begin
            fail_mask[cur_idx] <= test_result_i;
            if (test_result_i && no_fail_yet) first_fail <= cur_idx;
`ifdef SEQ_STOP_ON_ERROR_EN
            state <= test_result_i ? DONE_S : NEXT_S;
`else
            state <= NEXT_S;
`endif
          end else if (wd_inc == '1) begin
            // Expiry when the counter reaches all-ones: 2**TIMEOUT_W-1 cycles spent waiting.
            fail_mask[cur_idx] <= 1'b1;
            if (no_fail_yet) first_fail <= cur_idx;
            timed_out <= 1'b1;
            state     <= DONE_S;
          end
        end
        NEXT_S: begin
          if (is_last) begin
            state <= DONE_S;
          end else begin
            cur_idx <= cur_idx + IDX_W'(1);
            state   <= LOAD_S;
          end
        end
        DONE_S:  state <= IDLE_S;
        default: state <= IDLE_S;
      endcase
    end
  end

  assign seq_busy_o       = (state != IDLE_S);
  assign seq_done_o       = (state == DONE_S);
  assign start_test_o     = (state == START_S);
  assign seq_fail_mask_o  = fail_mask;
  assign seq_first_fail_o = first_fail;
  assign seq_timeout_o    = timed_out;
  assign test_param_o     = param;
  assign dbg_state_o      = state;

endmodule

// File: tb/tb_test_sequencer.sv
// Randomized scoreboard bench for test_sequencer with a behavioural control_block responder.
module tb_test_sequencer;
  localparam int DN = 4;
  localparam int TW = 4;
  localparam int IW = 2;
  localparam int TO_GAP = (1 << TW) - 1 + 1;  // waiting cycles before expiry, then the done cycle
`ifdef SEQ_STOP_ON_ERROR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              desc_we_i = 1'b0;
  logic [IW-1:0]     desc_idx_i = '0;
  logic [2:1][31:0]  desc_data_i = '0;
  logic [IW:0]       seq_num_i = '0;
  logic              seq_start_i = 1'b0;
  logic              seq_busy_o, seq_done_o, seq_timeout_o, start_test_o;
  logic [DN-1:0]     seq_fail_mask_o;
  logic [IW-1:0]     seq_first_fail_o;
  logic [2:1][31:0]  test_param_o;
  logic              test_finished_i = 1'b0;
  logic              test_result_i = 1'b0;
  logic [2:0]        dbg_state_o;

  test_sequencer #(.DESC_NUM(DN), .TIMEOUT_W(TW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .desc_we_i(desc_we_i), .desc_idx_i(desc_idx_i),
    .desc_data_i(desc_data_i), .seq_num_i(seq_num_i), .seq_start_i(seq_start_i),
    .seq_busy_o(seq_busy_o), .seq_done_o(seq_done_o), .seq_fail_mask_o(seq_fail_mask_o),
    .seq_first_fail_o(seq_first_fail_o), .seq_timeout_o(seq_timeout_o),
    .start_test_o(start_test_o), .test_param_o(test_param_o),
    .test_finished_i(test_finished_i), .test_result_i(test_result_i),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset observation
  always #5 clk = ~clk;
  logic rst_low_edge = 1'b1;
  initial forever begin
    @(posedge clk);
    rst_low_edge = !rst_n_i;
  end

  // scoreboard state; result word = {starts[10:7], timeout[6], first[5:4], mask[3:0]}
  logic [63:0] exp_q[$];
  logic [10:0] exp_res_q[$];
  logic [63:0] slot_m [DN];
  bit          plan_res [DN];
  bit          plan_to [DN];
  int          resp_idx = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // control_block model: answers each start after a random delay unless planned to hang
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (start_test_o && !rst_low_edge) begin
        idx = resp_idx;
        resp_idx++;
        if (idx < DN && !plan_to[idx]) begin
          repeat ($urandom_range(1, 6)) @(negedge clk);
          test_finished_i = 1'b1;
          test_result_i   = plan_res[idx];
          @(negedge clk);
          test_finished_i = 1'b0;
          test_result_i   = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // monitor
  initial begin
    int cyc = 0;
    int last_start = 0;
    int run_starts = 0;
    logic [10:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_low_edge) begin
        check("reset_outputs", {start_test_o, seq_done_o, seq_busy_o, seq_timeout_o, seq_fail_mask_o}, '0);
        run_starts = 0;
      end else begin
        if (start_test_o) begin
          run_starts++;
          last_start = cyc;
          if (exp_q.size() == 0) check("unexpected_start", 1, 0);
          else check("test_param", test_param_o, exp_q.pop_front());
        end
        if (seq_done_o) begin
          if (exp_res_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_res_q.pop_front();
            check("fail_mask", seq_fail_mask_o, e[3:0]);
            check("timeout_flag", seq_timeout_o, e[6]);
            check("start_count", run_starts, e[10:7]);
            if (e[3:0] != 0) check("first_fail", seq_first_fail_o, e[5:4]);
            if (e[6]) check("timeout_gap", cyc - last_start, TO_GAP);
          end
          run_starts = 0;
          done_cnt++;
        end
      end
    end
  end

  // driver tasks
  task automatic write_slot(input int idx, input logic [63:0] d);
    @(negedge clk);
    desc_we_i = 1'b1;
    desc_idx_i = IW'(idx);
    desc_data_i = d;
    @(negedge clk);
    desc_we_i = 1'b0;
    slot_m[idx] = d;
  endtask

  task automatic set_plan(input logic [3:0] res, input logic [3:0] to);
    for (int i = 0; i < DN; i++) begin
      plan_res[i] = res[i];
      plan_to[i]  = to[i];
    end
  endtask

  task automatic run_seq(input int num_req, input bit poke, input bit we_start);
    logic [63:0] new_data;
    logic [3:0]  m;
    logic [1:0]  f;
    bit          to;
    int          n, starts, base;
    bit          seen;
    new_data = {$urandom, $urandom};
    if (we_start) slot_m[0] = new_data;
    n = (num_req > DN) ? DN : num_req;
    m = '0; f = '0; to = 1'b0; starts = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(slot_m[i]);
      starts++;
      if (plan_to[i]) begin
        if (m == 0) f = 2'(i);
        m[i] = 1'b1;
        to = 1'b1;
        break;
      end
      if (plan_res[i]) begin
        if (m == 0) f = 2'(i);
        m[i] = 1'b1;
        if (STOP_ON_ERR) break;
      end
    end
    exp_res_q.push_back({4'(starts), to, f, m});
    resp_idx = 0;
    @(negedge clk);
    seq_num_i = 3'(num_req);
    seq_start_i = 1'b1;
    if (we_start) begin
      desc_we_i = 1'b1;
      desc_idx_i = '0;
      desc_data_i = new_data;
    end
    base = done_cnt;
    @(negedge clk);
    seq_start_i = 1'b0;
    desc_we_i = 1'b0;
    check("busy_after_start", seq_busy_o, 1);
    seen = 1'b0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      @(negedge clk);
      if (c == 1 && n > 0) check("start_latency", start_test_o, 1);
      if (poke && c == 3) begin
        seq_start_i = 1'b1;
        seq_num_i = 3'd1;
        desc_we_i = 1'b1;
        desc_idx_i = '0;
        desc_data_i = ~slot_m[0];
      end else if (c == 4) begin
        seq_start_i = 1'b0;
        desc_we_i = 1'b0;
      end
      if (done_cnt != base) seen = 1'b1;
    end
    seq_start_i = 1'b0;
    desc_we_i = 1'b0;
    if (!seen) begin
      check("done_wait", 0, 1);
    end else begin
      repeat (2) @(negedge clk);
      check("mask_held", seq_fail_mask_o, m);
      check("idle_after_done", seq_busy_o, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < DN; i++) slot_m[i] = '0;
    set_plan(4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    check("rst_mask", seq_fail_mask_o, 0);
    check("rst_first", seq_first_fail_o, 0);
    check("rst_param", test_param_o, 0);
    check("rst_busy", seq_busy_o, 0);

    for (int i = 0; i < DN; i++) write_slot(i, {$urandom, $urandom});
    set_plan(4'b0000, 4'b0000); run_seq(3, 0, 0);   // clean pass of three tests
    set_plan(4'b1010, 4'b0000); run_seq(4, 0, 0);   // failures at 1 and 3
    set_plan(4'b0000, 4'b0010); run_seq(3, 0, 0);   // test 1 never finishes
    set_plan(4'b0000, 4'b0000); run_seq(0, 0, 0);   // empty sequence
    set_plan(4'b0101, 4'b0000); run_seq(7, 0, 0);   // clamped to DESC_NUM
    set_plan(4'b0000, 4'b0000); run_seq(3, 1, 0);   // start/write while busy ignored
    set_plan(4'b0000, 4'b0000); run_seq(2, 0, 0);   // slot 0 must be unchanged
    set_plan(4'b0010, 4'b0000); run_seq(2, 0, 1);   // write same cycle as start

    // reset while waiting on test 0
    set_plan(4'b0000, 4'b0001);
    exp_q.push_back(slot_m[0]);
    resp_idx = 0;
    @(negedge clk);
    seq_num_i = 3'd3;
    seq_start_i = 1'b1;
    @(negedge clk);
    seq_start_i = 1'b0;
    repeat (8) @(negedge clk);
    check("wait_busy", seq_busy_o, 1);
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
    exp_q.delete();
    exp_res_q.delete();
    for (int i = 0; i < DN; i++) slot_m[i] = '0;
    @(negedge clk);
    check("rst2_mask", seq_fail_mask_o, 0);
    check("rst2_timeout", seq_timeout_o, 0);
    check("rst2_param", test_param_o, 0);
    set_plan(4'b0000, 4'b0000); run_seq(2, 0, 0);   // fresh run from cleared slots

    for (int r = 0; r < 12; r++) begin
      logic [3:0] res, tmo;
      write_slot($urandom_range(0, DN - 1), {$urandom, $urandom});
      write_slot($urandom_range(0, DN - 1), {$urandom, $urandom});
      res = 4'($urandom_range(0, 15));
      tmo = '0;
      for (int i = 0; i < DN; i++) tmo[i] = ($urandom_range(0, 7) == 0);
      set_plan(res, tmo);
      run_seq($urandom_range(0, 7), 0, 0);
    end

    repeat (4) @(negedge clk);
    check("param_q_empty", exp_q.size(), 0);
    check("result_q_empty", exp_res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
